// File: rtl/cmult_sched.sv
// Round-robin scheduler that shares one pipelined complex multiplier among NREQ requesters.
// Each product returns with its requester ID through a valid/ID pipe matched to the multiplier latency.
module cmult_sched #(
    parameter int NREQ   = 4,
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 18,
    parameter int LAT    = 6,
    parameter int IDW    = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic                            i_flush,
    input  logic [NREQ-1:0]                 i_req_valid,
    output logic [NREQ-1:0]                 o_req_ready,
    input  logic [NREQ*AWIDTH-1:0]          i_req_are,
    input  logic [NREQ*AWIDTH-1:0]          i_req_aim,
    input  logic [NREQ*BWIDTH-1:0]          i_req_bre,
    input  logic [NREQ*BWIDTH-1:0]          i_req_bim,
    output logic                            o_m_ce,
    output logic [AWIDTH-1:0]               o_m_are,
    output logic [AWIDTH-1:0]               o_m_aim,
    output logic [BWIDTH-1:0]               o_m_bre,
    output logic [BWIDTH-1:0]               o_m_bim,
    input  logic [AWIDTH+BWIDTH:0]          i_m_pre,
    input  logic [AWIDTH+BWIDTH:0]          i_m_pim,
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic [IDW-1:0]                  o_rsp_id,
    output logic [AWIDTH+BWIDTH:0]          o_rsp_pre,
    output logic [AWIDTH+BWIDTH:0]          o_rsp_pim,
    output logic                            o_busy,
    output logic                            o_flush_done
);

    localparam int CW = $clog2(LAT + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic              s0_vld_q;
    logic [IDW-1:0]    s0_id_q;
    logic [AWIDTH-1:0] are_q, aim_q;
    logic [BWIDTH-1:0] bre_q, bim_q;
    logic [LAT-1:0]    vld_pipe_q;
    logic [IDW-1:0]    id_pipe_q [LAT];

    logic              ce_s;
    logic              rsp_valid_s;
    logic              rsp_hs_s;
    logic              accept_s;
    logic              flush_done_s;
    logic              pass_ok_s;
    logic [NREQ-1:0]   grant_s;
    logic [IDW-1:0]    grant_id_s;
    logic [AWIDTH-1:0] sel_are_s, sel_aim_s;
    logic [BWIDTH-1:0] sel_bre_s, sel_bim_s;

    // A product held at the output with no taker freezes the whole datapath
    assign rsp_valid_s = vld_pipe_q[LAT-1];
    assign ce_s        = ~(rsp_valid_s & ~i_rsp_ready);
    assign rsp_hs_s    = rsp_valid_s & i_rsp_ready;

    // Round-robin pick: first pass scans from the pointer upward, second pass wraps below it
    always_comb begin
        grant_s    = '0;
        grant_id_s = '0;
        accept_s   = 1'b0;
        pass_ok_s  = 1'b0;
        sel_are_s  = '0;
        sel_aim_s  = '0;
        sel_bre_s  = '0;
        sel_bim_s  = '0;
        if ((state_q == ST_RUN) && ce_s) begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (pass == 0) begin
                        pass_ok_s = (IDW'(k) >= rr_q);
                    end else begin
                        pass_ok_s = (IDW'(k) < rr_q);
                    end
                    if (!accept_s && i_req_valid[k] && pass_ok_s) begin
                        accept_s   = 1'b1;
                        grant_s[k] = 1'b1;
                        grant_id_s = IDW'(k);
                        sel_are_s  = i_req_are[k*AWIDTH +: AWIDTH];
                        sel_aim_s  = i_req_aim[k*AWIDTH +: AWIDTH];
                        sel_bre_s  = i_req_bre[k*BWIDTH +: BWIDTH];
                        sel_bim_s  = i_req_bim[k*BWIDTH +: BWIDTH];
                    end
                end
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Pointer moves just past the winner; it holds when nobody is accepted
    always_comb begin
        rr_d = rr_q;
        if (accept_s) begin
            if (grant_id_s == IDW'(NREQ - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = grant_id_s + IDW'(1);
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Outstanding-product count; simultaneous accept and return cancel out
    always_comb begin
        inflight_d = inflight_q;
        case ({accept_s, rsp_hs_s})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Mode FSM: flush overrides enable, and drain exits only once nothing is outstanding
    always_comb begin
        state_d      = state_q;
        flush_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_flush) begin
                    state_d = ST_DRAIN;
                end else if (i_en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_flush) begin
                    state_d = ST_DRAIN;
                end else if (!i_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == '0) begin
                    flush_done_s = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
        end
    end

    // Operand stage: operands hold when idle so the multiplier inputs stay quiet
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_vld_q <= 1'b0;
            s0_id_q  <= '0;
            are_q    <= '0;
            aim_q    <= '0;
            bre_q    <= '0;
            bim_q    <= '0;
        end else if (ce_s) begin
            s0_vld_q <= accept_s;
            if (accept_s) begin
                s0_id_q <= grant_id_s;
                are_q   <= sel_are_s;
                aim_q   <= sel_aim_s;
                bre_q   <= sel_bre_s;
                bim_q   <= sel_bim_s;
            end
        end
    end

    // Tag pipe mirrors the multiplier latency; reset clears it so stale products are masked
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                id_pipe_q[i] <= '0;
            end
        end else if (ce_s) begin
            vld_pipe_q[0] <= s0_vld_q;
            id_pipe_q[0]  <= s0_id_q;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                id_pipe_q[i]  <= id_pipe_q[i-1];
            end
        end
    end

    assign o_req_ready  = grant_s;
    assign o_m_ce       = ce_s;
    assign o_m_are      = are_q;
    assign o_m_aim      = aim_q;
    assign o_m_bre      = bre_q;
    assign o_m_bim      = bim_q;
    assign o_rsp_valid  = rsp_valid_s;
    assign o_rsp_id     = id_pipe_q[LAT-1];
    assign o_rsp_pre    = i_m_pre;
    assign o_rsp_pim    = i_m_pim;
    assign o_busy       = (inflight_q != '0);
    assign o_flush_done = flush_done_s;

endmodule
